instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch path: word size, NOP encoding,
// fetch FSM states and the {pc, insn} prefetch entry.
package riscv_fetch_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, insn} entries. Entry 0 is always the head,
// so the head outputs come straight from a register.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_entry,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_idx  = count_q - CW'(do_pop);
    ent_d   = ent_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      // Shift only occupied slots so that draining to empty leaves the last
      // head in entry 0.
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (do_pop && (CW'(i + 1) < count_q)) ent_d[i] = ent_q[i + 1];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_push && (CW'(i) == wr_idx)) ent_d[i] = push_entry;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{pc: '0, insn: NOP_INSN};
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a
// prefetch queue, with redirect flush and discard of stale responses.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] target, next_pc;
  logic [CW:0]     occ_after;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    push_entry, head;

  assign target     = word_align(redirect_pc);
  assign next_pc    = addr_q + 32'd4;
  assign q_pop      = !q_empty && inst_ready && !redirect;
  assign q_push     = (state_q == ST_REQ) && mem_ack && !redirect;
  assign push_entry = '{pc: addr_q, insn: mem_rdata};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (q_push),
    .pop        (q_pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    occ_after  = {1'b0, q_count} + (CW + 1)'(q_push) - (CW + 1)'(q_pop);
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
          addr_d     = target;
          state_d    = ST_REQ;
        end else if (!q_full) begin
          addr_d  = fetch_pc_q;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (mem_ack) addr_d = target;
          else         state_d = ST_DROP;
        end else if (mem_ack) begin
          fetch_pc_d = next_pc;
          if (occ_after < (CW + 1)'(QDEPTH)) addr_d = next_pc;
          else                               state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        // mem_addr stays on the abandoned request until memory acks it.
        if (redirect) begin
          fetch_pc_d = target;
          if (mem_ack) begin
            addr_d  = target;
            state_d = ST_REQ;
          end
        end else if (mem_ack) begin
          addr_d  = fetch_pc_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign inst_valid = !q_empty;
  assign inst_pc    = head.pc;
  assign inst_data  = head.insn;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios followed by
// randomized memory latency, redirects, back-pressure and occasional resets.
module tb_instruction_fetch_unit;

  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb[$];
  logic [31:0] model_pc = RESET_PC;
  bit          stale = 1'b0;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_pc     (inst_pc),
    .inst_data   (inst_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then update the
  // reference model from what memory saw once the rising edge has passed.
  task automatic step(input bit rst, input bit ack, input bit redir,
                      input logic [31:0] rpc, input bit rdy);
    bit          a_eff, req;
    logic [31:0] addr;
    req         = mem_req;
    addr        = mem_addr;
    a_eff       = ack && req;
    reset       = rst;
    mem_ack     = a_eff;
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    mem_rdata   = memf(addr);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      model_pc = RESET_PC;
      stale    = 1'b0;
    end else begin
      if (a_eff) begin
        if (!redir && !stale) begin
          check("fetch_addr", addr, model_pc);
          sb.push_back({addr, memf(addr)});
          model_pc = addr + 32'd4;
          check("occupancy_le_depth", sb.size() <= QDEPTH, 1);
        end
        stale = 1'b0;
      end else if (redir && req) begin
        stale = 1'b1;
      end
      if (redir) begin
        sb.delete();
        model_pc = rpc & ~32'h3;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every accepted instruction.
  initial begin
    logic [63:0] e;
    bit          prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        check("valid_vs_model", inst_valid, sb.size() != 0);
        if (inst_valid && inst_ready && !redirect) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc=%h with nothing expected", inst_pc);
          end else begin
            e = sb.pop_front();
            check("inst_pc", inst_pc, e[63:32]);
            check("inst_data", inst_data, e[31:0]);
          end
        end
        if (prev_req && !prev_ack && !prev_rst)
          check("addr_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
        check("addr_align", mem_addr[1:0], 0);
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
      prev_rst  = reset;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_data", inst_data, NOP);

    // Streaming: one instruction per cycle from address 0 upward.
    step(0, 1, 0, 0, 1);
    check("first_req", {mem_req, mem_addr}, {1'b1, RESET_PC});
    for (int i = 0; i < 8; i++) begin
      check("stream_addr", mem_addr, 32'(4 * i));
      step(0, 1, 0, 0, 1);
      check("stream_head", {inst_valid, inst_pc}, {1'b1, 32'(4 * i)});
    end

    // Back-pressure: only QDEPTH responses accepted, then drain and resume at 8.
    step(1, 0, 0, 0, 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) acks++;
      step(0, 1, 0, 0, 0);
    end
    check("bp_ack_count", acks, 2);
    check("bp_req_off", mem_req, 0);
    check("bp_head", {inst_valid, inst_pc}, {1'b1, 32'h0});
    step(0, 0, 0, 0, 1);
    check("bp_drain", {inst_valid, inst_pc}, {1'b1, 32'h4});
    step(0, 0, 0, 0, 1);
    check("bp_resume", {mem_req, mem_addr}, {1'b1, 32'h8});
    step(0, 1, 0, 0, 1);

    // Redirect while a slow response to 0x10 is outstanding.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    check("drop_at_10", mem_addr, 32'h10);
    step(0, 0, 1, 32'h103, 1);
    check("drop_hold1", {mem_req, mem_addr, inst_valid}, {1'b1, 32'h10, 1'b0});
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("drop_hold3", {mem_req, mem_addr}, {1'b1, 32'h10});
    step(0, 1, 0, 0, 1);
    check("drop_next", {mem_req, mem_addr, inst_valid}, {1'b1, 32'h100, 1'b0});

    // Redirect coincident with an ack.
    step(0, 1, 1, 32'h20, 1);
    check("redir_ack_20", mem_addr, 32'h20);
    step(0, 1, 1, 32'h200, 1);
    check("redir_ack_200", {mem_req, mem_addr, inst_valid}, {1'b1, 32'h200, 1'b0});

    // Address wrap at the top of the space; low redirect bits ignored.
    step(0, 1, 1, 32'hFFFF_FFFF, 1);
    check("wrap_target", mem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 1);
    check("wrap_next", mem_addr, 32'h0);
    check("wrap_head", {inst_valid, inst_pc}, {1'b1, 32'hFFFF_FFFC});

    // Reset mid-request with a queued entry overrides ack and redirect.
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h300, 1);
    check("midrst_state", {inst_valid, mem_req, mem_addr}, {1'b0, 1'b0, RESET_PC});
    check("midrst_head", {inst_pc, inst_data}, {32'h0, NOP});
    step(0, 1, 0, 0, 1);
    check("midrst_restart", {mem_req, mem_addr}, {1'b1, RESET_PC});

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 999) < 3,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 5,
           $urandom,
           $urandom_range(0, 99) < 65);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
